// File: rtl/c16_pkg.sv
// Shared definitions for the c16 memory/writeback stage: executor op codes,
// stage state encoding and the value written back when a load times out.
package c16_pkg;

    typedef enum logic [1:0] {
        OP_WB_ALU = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_NONE   = 2'd3
    } xop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_e;

    localparam logic [15:0] LOAD_ERR_VALUE = 16'hDEAD;

    // True for ops that need a data-memory access.
    function automatic logic isMemOp(input xop_e op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/c16_mem_wb_if.sv
// Signal bundle between executor, memory/writeback stage, data memory and
// register file. The slave modport is the stage's own view; master is the
// view of the surrounding pipeline/environment that drives it.
interface c16_mem_wb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int REG_AW = 3
);
    logic              x_valid;
    logic [1:0]        x_op;
    logic [REG_AW-1:0] x_dest;
    logic [DATA_W-1:0] x_value;
    logic [ADDR_W-1:0] x_addr;
    logic              x_ready;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    logic              wb_enable;
    logic [REG_AW-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic              err;

    modport slave (
        input  x_valid, x_op, x_dest, x_value, x_addr,
        output x_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output wb_enable, wb_dest, wb_value,
        output err
    );

    modport master (
        output x_valid, x_op, x_dest, x_value, x_addr,
        input  x_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  wb_enable, wb_dest, wb_value,
        input  err
    );

endinterface

// File: rtl/c16_wait_timer.sv
// Load-response watchdog: counts cycles spent waiting for read data,
// saturates at 255 so it can never wrap back to a small value, and flags
// the cycle in which the count would reach LIMIT.
module c16_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [7:0] LIMIT_L = 8'(LIMIT);

    logic [7:0] r_count;
    logic [7:0] w_countNext;

    // Saturating increment of the wait count.
    always_comb begin
        w_countNext = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
    end

    // Count register: cleared on entry to the wait, advanced while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_run) begin
            r_count <= w_countNext;
        end
    end

    assign o_expired = i_run && (w_countNext >= LIMIT_L);

endmodule

// File: rtl/c16_mem_wb.sv
// c16 memory/writeback stage. ALU results are written back one cycle after
// acceptance; loads and stores run a single outstanding req/gnt/rvalid
// access, during which the executor is held off via x_ready.
module c16_mem_wb
    import c16_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    c16_mem_wb_if.slave bus
);

    state_e            r_state;
    state_e            w_nextState;

    logic              r_isStore;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_AW-1:0] r_dest;

    logic              r_wbEnable;
    logic [REG_AW-1:0] r_wbDest;
    logic [DATA_W-1:0] r_wbValue;
    logic              r_err;

    xop_e              w_op;
    logic              w_accept;
    logic              w_timerClear;
    logic              w_timerRun;
    logic              w_timerExpired;

    assign w_op         = xop_e'(bus.x_op);
    assign w_accept     = bus.x_valid && (r_state == S_IDLE);
    assign w_timerClear = (r_state == S_REQ) && bus.dmem_gnt && !r_isStore;
    assign w_timerRun   = (r_state == S_WAIT) && !bus.dmem_rvalid;

    c16_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_waitTimer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timerClear),
        .i_run     (w_timerRun),
        .o_expired (w_timerExpired)
    );

    // State register; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode for the access sequence IDLE -> REQ -> (WAIT -> WB).
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && isMemOp(w_op)) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.dmem_gnt) begin
                    w_nextState = r_isStore ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.dmem_rvalid || w_timerExpired) begin
                    w_nextState = S_WB;
                end
            end
            S_WB: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Request latches, writeback registers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_isStore  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dest     <= '0;
            r_wbEnable <= 1'b0;
            r_wbDest   <= '0;
            r_wbValue  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wbEnable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_op == OP_WB_ALU) begin
                            r_wbEnable <= 1'b1;
                            r_wbDest   <= bus.x_dest;
                            r_wbValue  <= bus.x_value;
                        end else if (isMemOp(w_op)) begin
                            r_isStore <= (w_op == OP_STORE);
                            r_addr    <= bus.x_addr;
                            r_wdata   <= bus.x_value;
                            r_dest    <= bus.x_dest;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_rvalid) begin
                        r_wbEnable <= 1'b1;
                        r_wbDest   <= r_dest;
                        r_wbValue  <= bus.dmem_rdata;
                    end else if (w_timerExpired) begin
                        r_wbEnable <= 1'b1;
                        r_wbDest   <= r_dest;
                        r_wbValue  <= DATA_W'(LOAD_ERR_VALUE);
                        r_err      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.x_ready    = (r_state == S_IDLE);
    assign bus.dmem_req   = (r_state == S_REQ);
    assign bus.dmem_we    = r_isStore;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_wdata = r_wdata;
    assign bus.wb_enable  = r_wbEnable;
    assign bus.wb_dest    = r_wbDest;
    assign bus.wb_value   = r_wbValue;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_c16_mem_wb.sv
// Self-checking bench for c16_mem_wb: expected writebacks go into a
// scoreboard queue when stimulus is driven and are popped by a monitor on
// every wb_enable cycle; handshake/memory outputs are checked directly.
module tb_c16_mem_wb;
    import c16_pkg::*;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] value;
    } wbExp_t;

    logic   clk;
    logic   reset;
    int     checks;
    int     failures;
    wbExp_t sbQ[$];

    c16_mem_wb_if #(.DATA_W(16), .ADDR_W(16), .REG_AW(3)) bus ();

    c16_mem_wb #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .REG_AW  (3),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [2:0] dest, input logic [15:0] value,
                                 input logic [15:0] addr);
        bus.x_valid = v;
        bus.x_op    = op;
        bus.x_dest  = dest;
        bus.x_value = value;
        bus.x_addr  = addr;
        if (v && op == OP_WB_ALU) begin
            sbQ.push_back('{dest, value});
        end
    endtask

    // Full load sequence with immediate grant; rvalidCycle is the WAIT cycle
    // (1-based) carrying read data, 0 means the memory never answers.
    task automatic runLoad(input logic [2:0] dest, input logic [15:0] addr,
                           input logic [15:0] rdata, input int rvalidCycle,
                           input logic [15:0] expValue);
        int last;
        applyStimulus(1'b1, OP_LOAD, dest, 16'h0000, addr);
        sbQ.push_back('{dest, expValue});
        @(negedge clk);
        checkOutput("ld_req", 32'(bus.dmem_req), 32'd1);
        checkOutput("ld_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("ld_addr", 32'(bus.dmem_addr), 32'(addr));
        bus.x_valid  = 1'b0;
        bus.dmem_gnt = 1'b1;
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        checkOutput("ld_wait_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("ld_wait_ready", 32'(bus.x_ready), 32'd0);
        last = (rvalidCycle != 0) ? rvalidCycle : TB_TIMEOUT;
        for (int c = 1; c < last; c++) begin
            @(negedge clk);
        end
        if (rvalidCycle != 0) begin
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rdata;
        end
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        checkOutput("ld_wb_en", 32'(bus.wb_enable), 32'd1);
        checkOutput("ld_wb_busy", 32'(bus.x_ready), 32'd0);
        @(negedge clk);
        checkOutput("ld_idle", 32'(bus.x_ready), 32'd1);
    endtask

    // Scoreboard monitor: every writeback cycle must match the oldest entry.
    always @(negedge clk) begin
        if (bus.wb_enable === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("wb_spurious", 32'(bus.wb_enable), 32'd0);
            end else begin
                wbExp_t e;
                e = sbQ.pop_front();
                checkOutput("wb_dest", 32'(bus.wb_dest), 32'(e.dest));
                checkOutput("wb_value", 32'(bus.wb_value), 32'(e.value));
            end
        end
    end

    // Main sequence.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, OP_NONE, 3'd0, 16'h0000, 16'h0000);
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 16'h0000;
        repeat (2) @(negedge clk);

        checkOutput("rst_x_ready", 32'(bus.x_ready), 32'd1);
        checkOutput("rst_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("rst_addr", 32'(bus.dmem_addr), 32'd0);
        checkOutput("rst_wb_en", 32'(bus.wb_enable), 32'd0);
        checkOutput("rst_wb_value", 32'(bus.wb_value), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;

        // ALU writeback, then back-to-back ALU ops
        applyStimulus(1'b1, OP_WB_ALU, 3'd3, 16'h1234, 16'h0000);
        @(negedge clk);
        checkOutput("alu_ready0", 32'(bus.x_ready), 32'd1);
        applyStimulus(1'b1, OP_WB_ALU, 3'd1, 16'h1111, 16'h0000);
        @(negedge clk);
        checkOutput("alu_ready1", 32'(bus.x_ready), 32'd1);
        applyStimulus(1'b1, OP_WB_ALU, 3'd2, 16'h2222, 16'h0000);
        @(negedge clk);
        checkOutput("alu_ready2", 32'(bus.x_ready), 32'd1);
        applyStimulus(1'b1, OP_WB_ALU, 3'd0, 16'h0F0F, 16'h0000);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, 3'd0, 16'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("alu_wb_off", 32'(bus.wb_enable), 32'd0);

        // Store with grant in the fourth request cycle
        applyStimulus(1'b1, OP_STORE, 3'd0, 16'hBEEF, 16'h0040);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.x_valid = 1'b0;
            checkOutput("st_req", 32'(bus.dmem_req), 32'd1);
            checkOutput("st_we", 32'(bus.dmem_we), 32'd1);
            checkOutput("st_addr", 32'(bus.dmem_addr), 32'h0040);
            checkOutput("st_wdata", 32'(bus.dmem_wdata), 32'hBEEF);
            checkOutput("st_ready", 32'(bus.x_ready), 32'd0);
            if (i == 3) bus.dmem_gnt = 1'b1;
        end
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        checkOutput("st_done_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("st_done_ready", 32'(bus.x_ready), 32'd1);
        checkOutput("st_no_wb", 32'(bus.wb_enable), 32'd0);

        // Load with rvalid in the second wait cycle
        runLoad(3'd5, 16'h0010, 16'h00A5, 2, 16'h00A5);
        checkOutput("ld_err_clear", 32'(bus.err), 32'd0);

        // rvalid coinciding with the timeout cycle wins over the timeout
        runLoad(3'd4, 16'h0018, 16'h4444, TB_TIMEOUT, 16'h4444);
        checkOutput("edge_err_clear", 32'(bus.err), 32'd0);

        // Load timeout
        runLoad(3'd6, 16'h0020, 16'h0000, 0, 16'hDEAD);
        checkOutput("to_err_set", 32'(bus.err), 32'd1);

        // Good load after a timeout: err stays sticky
        runLoad(3'd7, 16'h0030, 16'h0077, 1, 16'h0077);
        checkOutput("to_err_sticky", 32'(bus.err), 32'd1);

        // Reset in WAIT drops the access; a late rvalid is ignored
        applyStimulus(1'b1, OP_LOAD, 3'd2, 16'h0000, 16'h0050);
        @(negedge clk);
        bus.x_valid  = 1'b0;
        bus.dmem_gnt = 1'b1;
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ready", 32'(bus.x_ready), 32'd1);
        checkOutput("mid_rst_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("mid_rst_err", 32'(bus.err), 32'd0);
        reset           = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 16'h9999;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        checkOutput("late_rvalid_wb", 32'(bus.wb_enable), 32'd0);
        checkOutput("late_rvalid_ready", 32'(bus.x_ready), 32'd1);

        // NONE op does nothing
        applyStimulus(1'b1, OP_NONE, 3'd1, 16'h5555, 16'h0030);
        @(negedge clk);
        checkOutput("none_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("none_wb", 32'(bus.wb_enable), 32'd0);
        checkOutput("none_ready", 32'(bus.x_ready), 32'd1);
        applyStimulus(1'b0, OP_NONE, 3'd0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("none_req_later", 32'(bus.dmem_req), 32'd0);

        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
